attractor_scan_ctrl: RTL and testbench
======================================

ATTRACTOR_SCAN_CTRL -- requirements
Module: attractor_scan_ctrl

Interface
REQ-001 Parameter MAX_STEPS, default 16, meaning step budget per initial state before timeout (legal 3..31).
REQ-002 Parameter LAST_INIT, default 8'hFF, meaning final initial state of a scan (scan covers 0..LAST_INIT).
REQ-003 clk  input  1  single clock, all state on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  pulse, begins a scan from init 0; ignored while busy.
REQ-006 abort  input  1  synchronous; returns controller to IDLE.
REQ-007 x  input  8  current gene-network state; network updates on posedge where load or step is high.
REQ-008 init_val  output  8  initial state driven to the network.
REQ-009 load  output  1  one-cycle pulse; network loads init_val.
REQ-010 step  output  1  network advance enable.
REQ-011 res_valid  output  1  result available; held until accepted.
REQ-012 res_ready  input  1  consumer accepts result when high with res_valid.
REQ-013 res_init  output  8  initial state of the reported result.
REQ-014 res_period  output  2  1 = fixed point, 2 = 2-cycle, 0 = timeout.
REQ-015 res_steps  output  5  steps issued before detection.
REQ-016 busy  output  1  high in any state except IDLE and DONE.
REQ-017 done  output  1  high in DONE (level).

Function
REQ-018 FSM states IDLE, LOAD, RUN, REPORT, DONE; one state per cycle minimum.
REQ-019 IDLE/DONE + start -> LOAD with init_val = 0, step count = 0, history cleared; done drops on leaving DONE.
REQ-020 LOAD: load = 1 for exactly one cycle, step = 0; next state RUN.
REQ-021 RUN, each cycle, priority order: (a) history depth >= 1 and x == h1 -> period 1; (b) depth >= 2 and x == h2 -> period 2; (c) step count == MAX_STEPS -> period 0; (d) else step = 1, h2 <= h1, h1 <= x, depth saturates at 2, step count + 1.
REQ-022 Step is 0 in any RUN cycle where (a), (b) or (c) hits; that cycle latches res_init/res_period/res_steps and moves to REPORT.
REQ-023 First RUN cycle sees x == init_val with empty history; it can never report a period.
REQ-024 REPORT: res_valid = 1, result fields stable; leave only on res_valid && res_ready.
REQ-025 On acceptance: init_val == LAST_INIT -> DONE, else init_val + 1 and LOAD; no 8-bit wrap past LAST_INIT.
REQ-026 Result throughput: one result per initial state, in increasing init order, none dropped or duplicated.
REQ-027 abort high in any state -> IDLE next cycle, res_valid/load/step = 0, done = 0; abort outranks start and acceptance in the same cycle.
REQ-028 step count 5 bits, never exceeds MAX_STEPS; res_steps = count at detection.

Reset
REQ-029 rst_n low asynchronously forces IDLE; init_val = 0, load = 0, step = 0, res_valid = 0, res_init = 0, res_period = 0, res_steps = 0, busy = 0, done = 0, history and depth cleared.
REQ-030 Reset mid-RUN or mid-REPORT discards the pending result; no res_valid after release until a new start.

Structure
REQ-031 State encoding and period codes (P_NONE = 0, P_FIXED = 1, P_CYCLE2 = 2) live in shared package gene_net_pkg.
REQ-032 History registers, depth counter and compare logic form sub-module attractor_detect (inputs x, shift, clear; outputs hit1, hit2).

Verification
REQ-033 Identity network (x holds loaded value), LAST_INIT = 0 -> one result: res_init 0, res_period 1, res_steps 1; then done.
REQ-034 Toggle network (x alternates init, ~init) -> res_period 2, res_steps 2 for every init.
REQ-035 Counter network (x + 1 per step), MAX_STEPS = 16 -> res_period 0, res_steps 16.
REQ-036 res_ready low 5 cycles during REPORT -> res_valid and fields stable 5 cycles, step and load stay 0, then single handoff.
REQ-037 LAST_INIT = 2, res_ready tied high -> exactly three results, init 0, 1, 2 in order, then done = 1 and busy = 0.
REQ-038 rst_n low in RUN, then abort in REPORT on a rerun -> IDLE both times, res_valid 0, no result emitted until next start.

Source files
------------

// File: rtl/gene_net_pkg.sv
// Shared types for the gene-network attractor scanner: FSM states, period
// codes and the packed result payload reported to the consumer.
package gene_net_pkg;

  localparam int unsigned XW     = 8;  // gene-network state width
  localparam int unsigned CNT_W  = 5;  // step counter width
  localparam int unsigned PER_W  = 2;  // period code width
  localparam int unsigned DEPTH_W = 2; // history depth counter width

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_REPORT = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef enum logic [PER_W-1:0] {
    P_NONE   = 2'd0,
    P_FIXED  = 2'd1,
    P_CYCLE2 = 2'd2
  } period_e;

  typedef struct packed {
    logic [XW-1:0]    init;
    period_e          period;
    logic [CNT_W-1:0] steps;
  } result_t;

  // Period code from the detector hits; fixed point outranks a 2-cycle.
  function automatic period_e classify(input logic hit1, input logic hit2);
    if (hit1)      return P_FIXED;
    else if (hit2) return P_CYCLE2;
    else           return P_NONE;
  endfunction

endpackage

// File: rtl/attractor_scan_ctrl_if.sv
// Bus between the scan controller and its host/network.
//   master : host side (drives start/abort/x/res_ready)
//   slave  : controller side (drives init_val/load/step/results/status)
interface attractor_scan_ctrl_if;
  import gene_net_pkg::*;

  logic             start;
  logic             abort;
  logic [XW-1:0]    x;
  logic             res_ready;
  logic [XW-1:0]    init_val;
  logic             load;
  logic             step;
  logic             res_valid;
  logic [XW-1:0]    res_init;
  logic [PER_W-1:0] res_period;
  logic [CNT_W-1:0] res_steps;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, x, res_ready,
    input  init_val, load, step, res_valid, res_init, res_period,
           res_steps, busy, done
  );

  modport slave (
    input  start, abort, x, res_ready,
    output init_val, load, step, res_valid, res_init, res_period,
           res_steps, busy, done
  );

endinterface

// File: rtl/attractor_detect.sv
// Two-deep history of visited network states with compare logic.
//   x     : current network state
//   shift : push x into history (h2 <= h1, h1 <= x)
//   clear : empty the history (outranks shift)
//   hit1  : x equals the previous state (fixed point)
//   hit2  : x equals the state two steps back (2-cycle)
module attractor_detect
  import gene_net_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [XW-1:0] x,
  input  logic          shift,
  input  logic          clear,
  output logic          hit1,
  output logic          hit2
);

  logic [XW-1:0]      h1_q, h1_d;
  logic [XW-1:0]      h2_q, h2_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;

  // History update; depth saturates at two valid entries.
  always_comb begin
    h1_d    = h1_q;
    h2_d    = h2_q;
    depth_d = depth_q;
    if (clear) begin
      h1_d    = '0;
      h2_d    = '0;
      depth_d = '0;
    end else if (shift) begin
      h2_d = h1_q;
      h1_d = x;
      if (depth_q != DEPTH_W'(2)) depth_d = depth_q + DEPTH_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h1_q    <= '0;
      h2_q    <= '0;
      depth_q <= '0;
    end else begin
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      depth_q <= depth_d;
    end
  end

  // Only valid history entries may produce a hit.
  assign hit1 = (depth_q != DEPTH_W'(0)) && (x == h1_q);
  assign hit2 = (depth_q == DEPTH_W'(2)) && (x == h2_q);

endmodule

// File: rtl/attractor_scan_ctrl.sv
// Attractor scan controller: loads every initial state 0..LAST_INIT into a
// gene network, steps it until a fixed point, a 2-cycle or the step budget
// is reached, and reports one result per initial state with valid/ready.
//   clk, rst_n     : clock, async active-low reset
//   bus (slave)    : start/abort control, network x/init_val/load/step,
//                    result res_valid/res_ready/res_init/res_period/res_steps,
//                    status busy/done
// step is decided in the same cycle from x (the network advances on the
// edge where step is high), so it is a combinational decode of the detector.
module attractor_scan_ctrl
  import gene_net_pkg::*;
#(
  parameter int unsigned   MAX_STEPS = 16,
  parameter logic [XW-1:0] LAST_INIT = 8'hFF
) (
  input  logic                clk,
  input  logic                rst_n,
  attractor_scan_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);

  state_e           state_q, state_d;
  logic [XW-1:0]    init_q, init_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  result_t          res_q, res_d;

  logic step_c;
  logic shift_c;
  logic clear_c;
  logic hit1;
  logic hit2;

  attractor_detect u_detect (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (bus.x),
    .shift (shift_c),
    .clear (clear_c),
    .hit1  (hit1),
    .hit2  (hit2)
  );

  // Next-state, counters, result capture and the step decision.
  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    step_c  = 1'b0;
    shift_c = 1'b0;
    clear_c = 1'b0;

    if (bus.abort) begin
      state_d = ST_IDLE;
      clear_c = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_d = ST_LOAD;
            init_d  = '0;
            cnt_d   = '0;
            clear_c = 1'b1;
          end
        end
        ST_LOAD: begin
          // History is emptied here so the first RUN cycle cannot hit.
          state_d = ST_RUN;
          cnt_d   = '0;
          clear_c = 1'b1;
        end
        ST_RUN: begin
          if (hit1 || hit2 || (cnt_q == MAX_CNT)) begin
            res_d.init   = init_q;
            res_d.period = classify(hit1, hit2);
            res_d.steps  = cnt_q;
            state_d      = ST_REPORT;
          end else begin
            step_c  = 1'b1;
            shift_c = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
        ST_REPORT: begin
          if (bus.res_ready) begin
            if (init_q == LAST_INIT) begin
              state_d = ST_DONE;
            end else begin
              init_d  = init_q + XW'(1);
              state_d = ST_LOAD;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      init_q  <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign bus.init_val   = init_q;
  assign bus.load       = (state_q == ST_LOAD);
  assign bus.step       = step_c;
  assign bus.res_valid  = (state_q == ST_REPORT);
  assign bus.res_init   = res_q.init;
  assign bus.res_period = res_q.period;
  assign bus.res_steps  = res_q.steps;
  assign bus.busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign bus.done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_attractor_scan_ctrl.sv
// Bench for attractor_scan_ctrl: a behavioural gene network drives x, and a
// trajectory-based reference model predicts each reported result.
module tb_attractor_scan_ctrl;
  import gene_net_pkg::*;

  localparam int unsigned MAXS = 16;
  localparam logic [7:0]  LAST = 8'd3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  attractor_scan_ctrl_if ifc ();

  attractor_scan_ctrl #(.MAX_STEPS(MAXS), .LAST_INIT(LAST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int vectors = 0;
  int miscompares = 0;
  int mode = 0; // 0 identity, 1 toggle, 2 counter, 3 random lookup table
  logic [7:0] lut [256];

  function automatic logic [7:0] net_f(input logic [7:0] v);
    case (mode)
      0:       return v;
      1:       return ~v;
      2:       return v + 8'd1;
      default: return lut[v];
    endcase
  endfunction

  // Network: loads init_val on load, advances on step.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ifc.x <= 8'd0;
    else if (ifc.load)  ifc.x <= ifc.init_val;
    else if (ifc.step)  ifc.x <= net_f(ifc.x);
  end

  // Reference: walk the trajectory init, f(init), ... and apply the
  // fixed-point / 2-cycle / budget rules to the k-th visited state.
  task automatic model(input logic [7:0] init, output logic [1:0] per,
                       output logic [4:0] st);
    logic [7:0] seq [0:31];
    bit found;
    found = 1'b0;
    per = 2'd0;
    st = 5'(MAXS);
    seq[0] = init;
    for (int k = 0; k <= int'(MAXS); k++) begin
      if (k > 0) seq[k] = net_f(seq[k-1]);
      if (!found && k >= 1 && seq[k] == seq[k-1]) begin
        per = 2'd1; st = 5'(k); found = 1'b1;
      end else if (!found && k >= 2 && seq[k] == seq[k-2]) begin
        per = 2'd2; st = 5'(k); found = 1'b1;
      end
      if (found) break;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid();
    for (int c = 0; c < 200 && ifc.res_valid !== 1'b1; c++) begin
      // start pulses while busy must be ignored
      ifc.start = ($urandom_range(0, 5) == 0) && (ifc.busy === 1'b1);
      tick();
    end
    ifc.start = 1'b0;
  endtask

  // Full scan of inits 0..LAST under the current network.
  task automatic run_scan(input int m, input bit rand_hold, input bit tie_ready);
    logic [1:0] eper;
    logic [4:0] est;
    int hold;
    mode = m;
    ifc.res_ready = tie_ready;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    check("start_load", ifc.load, 1'b1);
    check("start_busy", ifc.busy, 1'b1);
    check("start_done", ifc.done, 1'b0);
    check("start_init", ifc.init_val, 8'd0);
    for (int i = 0; i <= int'(LAST); i++) begin
      model(8'(i), eper, est);
      wait_valid();
      check("res_valid", ifc.res_valid, 1'b1);
      check("res_init", ifc.res_init, 32'(i));
      check("res_period", ifc.res_period, eper);
      check("res_steps", ifc.res_steps, est);
      if (!tie_ready) begin
        hold = rand_hold ? int'($urandom_range(1, 5)) : 5;
        for (int h = 0; h < hold; h++) begin
          tick();
          check("hold_valid", ifc.res_valid, 1'b1);
          check("hold_init", ifc.res_init, 32'(i));
          check("hold_period", ifc.res_period, eper);
          check("hold_steps", ifc.res_steps, est);
          check("hold_step", ifc.step, 1'b0);
          check("hold_load", ifc.load, 1'b0);
        end
        ifc.res_ready = 1'b1;
      end
      tick();
      if (!tie_ready) ifc.res_ready = 1'b0;
      check("after_accept_valid", ifc.res_valid, 1'b0);
    end
    check("scan_done", ifc.done, 1'b1);
    check("scan_busy", ifc.busy, 1'b0);
    ifc.res_ready = 1'b0;
  endtask

  initial begin
    int nvalid;
    rst_n = 1'b0;
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    ifc.res_ready = 1'b0;
    for (int v = 0; v < 256; v++) lut[v] = 8'(v);
    tick(); tick(); tick();
    check("rst_busy", ifc.busy, 1'b0);
    check("rst_done", ifc.done, 1'b0);
    check("rst_valid", ifc.res_valid, 1'b0);
    check("rst_init_val", ifc.init_val, 8'd0);
    check("rst_load", ifc.load, 1'b0);
    check("rst_step", ifc.step, 1'b0);
    check("rst_res_init", ifc.res_init, 8'd0);
    check("rst_res_period", ifc.res_period, 2'd0);
    check("rst_res_steps", ifc.res_steps, 5'd0);
    rst_n = 1'b1;
    tick();

    run_scan(0, 1'b0, 1'b0);   // identity: fixed point after one step
    run_scan(1, 1'b1, 1'b0);   // toggle: 2-cycle after two steps
    run_scan(2, 1'b1, 1'b1);   // counter: budget timeout, ready tied high
    for (int r = 0; r < 4; r++) begin
      for (int v = 0; v < 256; v++) lut[v] = 8'($urandom_range(0, 7));
      run_scan(3, 1'b1, r[0]);
    end

    // Asynchronous reset in the middle of RUN.
    mode = 2;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    tick(); tick(); tick();
    check("mid_run_busy", ifc.busy, 1'b1);
    check("mid_run_step", ifc.step, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", ifc.busy, 1'b0);
    check("arst_valid", ifc.res_valid, 1'b0);
    check("arst_step", ifc.step, 1'b0);
    check("arst_init_val", ifc.init_val, 8'd0);
    tick();
    rst_n = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (ifc.res_valid === 1'b1) nvalid++;
    end
    check("no_result_after_reset", 32'(nvalid), 32'd0);
    check("idle_after_reset", ifc.busy, 1'b0);

    // Abort in REPORT, together with start and acceptance.
    mode = 2;
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    wait_valid();
    check("pre_abort_valid", ifc.res_valid, 1'b1);
    ifc.abort = 1'b1;
    ifc.start = 1'b1;
    ifc.res_ready = 1'b1;
    tick();
    ifc.abort = 1'b0;
    ifc.start = 1'b0;
    ifc.res_ready = 1'b0;
    check("abort_valid", ifc.res_valid, 1'b0);
    check("abort_busy", ifc.busy, 1'b0);
    check("abort_done", ifc.done, 1'b0);
    check("abort_load", ifc.load, 1'b0);
    check("abort_step", ifc.step, 1'b0);
    nvalid = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (ifc.res_valid === 1'b1 || ifc.busy === 1'b1) nvalid++;
    end
    check("no_activity_after_abort", 32'(nvalid), 32'd0);

    run_scan(1, 1'b1, 1'b0);   // recovers cleanly after abort

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
